// File: rtl/int_dispatch_if.sv
// Handshake bundle between the interrupt queue / multicycle CPU and the dispatch controller.
// master = controller side, slave = queue + CPU side.
interface int_dispatch_if;
    logic        q_valid;
    logic [2:0]  q_mode;
    logic        q_dequeue;
    logic        instr_boundary;
    logic [31:0] pc_next;
    logic        eret;
    logic        ie_write;
    logic        ie_wdata;
    logic        take_int;
    logic        take_ret;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        ie;
    logic        in_handler;
    logic [7:0]  spurious_cnt;

    modport master (
        input  q_valid, q_mode, instr_boundary, pc_next, eret, ie_write, ie_wdata,
        output q_dequeue, take_int, take_ret, redirect_pc, epc, cause, ie,
               in_handler, spurious_cnt
    );

    modport slave (
        output q_valid, q_mode, instr_boundary, pc_next, eret, ie_write, ie_wdata,
        input  q_dequeue, take_int, take_ret, redirect_pc, epc, cause, ie,
               in_handler, spurious_cnt
    );
endinterface

// File: rtl/int_dispatch_ctrl.sv
// Consumer of the interrupt-mode queue: takes the head entry at an instruction
// boundary, vectors the CPU per mode, and restores the PC on eret.
module int_dispatch_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
    parameter logic [31:0] VEC_STRIDE = 32'd16,
    parameter logic        IE_RESET   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    int_dispatch_if.master bus
);
    typedef enum logic [2:0] {IDLE, DROP, ACCEPT, HANDLER, RETURN} state_t;

    state_t      state, state_n;
    logic        deq_q, deq_n;
    logic        tint_q, tint_n;
    logic        tret_q, tret_n;
    logic [31:0] redir_q, redir_n;
    logic [31:0] epc_q, epc_n;
    logic [2:0]  cause_q, cause_n;
    logic        ie_q, ie_n;
    logic [7:0]  spur_q, spur_n;
    logic        accept;

    assign accept = bus.q_valid & ie_q & bus.instr_boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            deq_q   <= 1'b0;
            tint_q  <= 1'b0;
            tret_q  <= 1'b0;
            redir_q <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            ie_q    <= IE_RESET;
            spur_q  <= '0;
        end else begin
            state   <= state_n;
            deq_q   <= deq_n;
            tint_q  <= tint_n;
            tret_q  <= tret_n;
            redir_q <= redir_n;
            epc_q   <= epc_n;
            cause_q <= cause_n;
            ie_q    <= ie_n;
            spur_q  <= spur_n;
        end
    end

    always_comb begin
        state_n = state;
        deq_n   = 1'b0;
        tint_n  = 1'b0;
        tret_n  = 1'b0;
        redir_n = redir_q;
        epc_n   = epc_q;
        cause_n = cause_q;
        // software write applies unless the FSM touches ie below
        ie_n    = bus.ie_write ? bus.ie_wdata : ie_q;
        spur_n  = spur_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    deq_n = 1'b1;
                    if (bus.q_mode == 3'd0) begin
                        state_n = DROP;
                        spur_n  = (spur_q == 8'hFF) ? spur_q : spur_q + 8'd1;
                    end else begin
                        state_n = ACCEPT;
                        tint_n  = 1'b1;
                        epc_n   = bus.pc_next;
                        cause_n = bus.q_mode;
                        ie_n    = 1'b0;
                        redir_n = VEC_BASE + 32'(bus.q_mode) * VEC_STRIDE;
                    end
                end
            end
            DROP:    state_n = IDLE;
            ACCEPT:  state_n = HANDLER;
            HANDLER: begin
                if (bus.eret) begin
                    state_n = RETURN;
                    tret_n  = 1'b1;
                    redir_n = epc_q;
                    ie_n    = 1'b1;
                end
            end
            RETURN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.q_dequeue    = deq_q;
    assign bus.take_int     = tint_q;
    assign bus.take_ret     = tret_q;
    assign bus.redirect_pc  = redir_q;
    assign bus.epc          = epc_q;
    assign bus.cause        = cause_q;
    assign bus.ie           = ie_q;
    assign bus.spurious_cnt = spur_q;
    assign bus.in_handler   = (state == ACCEPT) || (state == HANDLER);
endmodule

// File: tb/tb_int_dispatch_ctrl.sv
// Randomized bench for int_dispatch_ctrl against an event-level model
// (busy/hold counters and a software queue), plus directed scenarios.
module tb_int_dispatch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_dispatch_if bus ();
    int_dispatch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int q[$];

    // model
    bit          m_deq, m_tint, m_tret, m_handler, m_ie;
    int          m_hold;
    int          m_spur;
    logic [31:0] m_redir, m_epc;
    logic [2:0]  m_cause;
    int          deq_seen;
    logic [31:0] last_int_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ie_old, fsm_ie;
        ie_old = m_ie;
        fsm_ie = 1'b0;
        if (rst) begin
            m_deq = 0; m_tint = 0; m_tret = 0; m_handler = 0; m_hold = 0;
            m_ie = 1'b1; m_spur = 0; m_redir = 0; m_epc = 0; m_cause = 0;
            return;
        end
        m_deq = 0; m_tint = 0; m_tret = 0;
        if (m_hold > 0) begin
            m_hold--;
        end else if (m_handler) begin
            if (bus.eret) begin
                m_tret = 1; m_redir = m_epc; m_ie = 1'b1; fsm_ie = 1'b1;
                m_handler = 0; m_hold = 1;
            end
        end else if (bus.q_valid && ie_old && bus.instr_boundary) begin
            m_deq = 1; m_hold = 1;
            if (bus.q_mode == 3'd0) begin
                if (m_spur < 255) m_spur++;
            end else begin
                m_tint = 1; m_epc = bus.pc_next; m_cause = bus.q_mode;
                m_redir = 32'h80 + 32'(bus.q_mode) * 32'd16;
                m_ie = 1'b0; fsm_ie = 1'b1; m_handler = 1;
            end
        end
        if (!fsm_ie && bus.ie_write) m_ie = bus.ie_wdata;
    endtask

    task automatic compare_all();
        chk("q_dequeue",    32'(bus.q_dequeue),    32'(m_deq));
        chk("take_int",     32'(bus.take_int),     32'(m_tint));
        chk("take_ret",     32'(bus.take_ret),     32'(m_tret));
        chk("redirect_pc",  bus.redirect_pc,       m_redir);
        chk("epc",          bus.epc,               m_epc);
        chk("cause",        32'(bus.cause),        32'(m_cause));
        chk("ie",           32'(bus.ie),           32'(m_ie));
        chk("in_handler",   32'(bus.in_handler),   32'(m_handler));
        chk("spurious_cnt", 32'(bus.spurious_cnt), 32'(m_spur));
    endtask

    // one clock: present queue head, model the edge, check #1 later, advance queue
    task automatic step();
        bus.q_valid = (q.size() > 0);
        bus.q_mode  = (q.size() > 0) ? 3'(q[0]) : 3'($urandom_range(0, 7));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (m_deq) begin
            deq_seen++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (m_tint) last_int_pc = bus.redirect_pc;
    endtask

    task automatic idle_inputs();
        bus.instr_boundary = 0; bus.eret = 0; bus.ie_write = 0; bus.ie_wdata = 0;
    endtask

    initial begin
        rst = 1; idle_inputs(); bus.pc_next = 0;
        deq_seen = 0; last_int_pc = 0;
        step(); step();
        rst = 0;

        // basic entry and return
        q.push_back(3); bus.instr_boundary = 1; bus.pc_next = 32'h100;
        step();
        chk("entry_redirect", bus.redirect_pc, 32'hB0);
        chk("entry_epc", bus.epc, 32'h100);
        bus.instr_boundary = 0;
        step(); step();
        chk("handler_hold", 32'(bus.in_handler), 32'd1);
        bus.eret = 1; step(); bus.eret = 0;
        chk("ret_redirect", bus.redirect_pc, 32'h100);
        step(); step();

        // two entries back to back with boundary held high
        deq_seen = 0;
        q.push_back(2); q.push_back(5); bus.instr_boundary = 1;
        for (int i = 0; i < 4; i++) step();
        bus.eret = 1; step(); bus.eret = 0;
        for (int i = 0; i < 4; i++) step();
        chk("second_vector", last_int_pc, 32'hD0);
        bus.eret = 1; step(); bus.eret = 0;
        step(); step();
        chk("two_dequeues", 32'(deq_seen), 32'd2);

        // spurious entries saturate
        for (int i = 0; i < 260; i++) q.push_back(0);
        for (int i = 0; i < 530; i++) step();
        chk("spur_sat", 32'(bus.spurious_cnt), 32'd255);
        q.delete();

        // ie disable blocks accept; FSM clear wins over same-cycle ie_write
        bus.ie_write = 1; bus.ie_wdata = 0; bus.instr_boundary = 0; step();
        bus.ie_write = 0; bus.instr_boundary = 1; q.push_back(1);
        deq_seen = 0;
        for (int i = 0; i < 3; i++) step();
        chk("ie_blocks", 32'(deq_seen), 32'd0);
        bus.ie_write = 1; bus.ie_wdata = 1; bus.instr_boundary = 0; step();
        bus.instr_boundary = 1; step();
        chk("fsm_ie_wins", 32'(bus.ie), 32'd0);
        idle_inputs();
        step(); bus.eret = 1; step(); bus.eret = 0; step(); step();

        // reset while in handler
        q.push_back(4); bus.instr_boundary = 1; bus.pc_next = 32'h2468;
        step(); bus.instr_boundary = 0; step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_epc", bus.epc, 32'h0);
        bus.eret = 1; step(); bus.eret = 0;
        chk("rst_no_ret", 32'(bus.take_ret), 32'd0);
        q.delete();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 6)
                q.push_back(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7));
            bus.instr_boundary = ($urandom_range(0, 2) != 0);
            bus.pc_next        = $urandom;
            bus.eret           = ($urandom_range(0, 5) == 0);
            bus.ie_write       = ($urandom_range(0, 15) == 0);
            bus.ie_wdata       = 1'($urandom_range(0, 3) != 0);
            rst                = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_dispatch_ctrl.md
Name: int_dispatch_ctrl

Overview:
Consumer-side controller for the interrupt-mode queue. It watches the queue's non-empty flag (Q) and head mode at CPU instruction boundaries. When interrupts are enabled, it accepts the head entry: saves the return PC into EPC, latches the cause, redirects the PC to a per-mode vector and pulses dequeue. It holds handler state until eret, then restores the PC and re-enables interrupts. It sits between the interrupt queue and the multicycle CPU's PC/control path.

Parameters:
VEC_BASE, 32'h0000_0080, address of mode-0 vector slot
VEC_STRIDE, 16, byte spacing between per-mode vectors
IE_RESET, 1'b1, value of interrupt-enable after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
q_valid  input  1  queue non-empty (queue Q output)
q_mode  input  3  mode at queue head
q_dequeue  output  1  one-cycle dequeue pulse to queue
instr_boundary  input  1  CPU is between instructions (about to fetch)
pc_next  input  32  address of the next instruction to execute (return address)
eret  input  1  one-cycle pulse: CPU executed eret
ie_write  input  1  software write to interrupt-enable
ie_wdata  input  1  value for ie_write
take_int  output  1  one-cycle pulse: CPU must load redirect_pc (interrupt entry)
take_ret  output  1  one-cycle pulse: CPU must load redirect_pc (return)
redirect_pc  output  32  target PC, valid while take_int or take_ret is high
epc  output  32  saved return address
cause  output  3  mode of the interrupt being serviced
ie  output  1  interrupt enable
in_handler  output  1  high in ACCEPT and HANDLER
spurious_cnt  output  8  saturating count of dropped mode-0 entries

Behaviour:
- Reset is synchronous: on a clk edge with rst=1, the FSM goes to IDLE and q_dequeue, take_int, take_ret, in_handler = 0. redirect_pc, epc, cause, spurious_cnt = 0. ie = IE_RESET. rst overrides every other input, including mid-handler; any in-flight entry is abandoned and no dequeue is issued.
- All outputs are registered. in_handler is decoded from the state register.
- FSM states: IDLE, DROP, ACCEPT, HANDLER, RETURN.
- IDLE:
  - accept condition = q_valid & ie & instr_boundary.
  - If accept and q_mode==0, go to DROP: q_dequeue=1 next cycle; spurious_cnt+1, saturating at 255.
  - If accept and q_mode!=0, go to ACCEPT. At that edge: epc<=pc_next, cause<=q_mode, ie<=0, q_dequeue<=1, take_int<=1, redirect_pc<=VEC_BASE+q_mode*VEC_STRIDE. Arithmetic is 32-bit; q_mode is zero-extended.
  - Otherwise stay in IDLE.
- DROP: one cycle, then IDLE. q_dequeue and take_int return to 0.
- ACCEPT: one cycle, then HANDLER. q_dequeue and take_int return to 0. Exactly one dequeue pulse is issued per accepted entry. The FSM cannot re-sample q_valid before the queue head advances.
- HANDLER: hold until eret=1. Then go to RETURN: take_ret<=1, redirect_pc<=epc, ie<=1. q_valid is ignored in this state (no nesting).
- RETURN: one cycle, then IDLE. take_ret returns to 0. A new accept is possible on the next boundary after that.
- eret in any state other than HANDLER is ignored.
- ie_write: ie<=ie_wdata in any state, except when the FSM writes ie in the same cycle. FSM writes (accept clears ie, eret sets it) take priority.
- Latency:
  - Boundary with a pending entry to take_int pulse: 1 cycle.
  - eret to take_ret: 1 cycle.
  - Minimum spacing between two interrupt entries: ACCEPT + HANDLER(≥1) + RETURN + 1.
- q_mode is sampled only on the accept edge; later head changes do not affect cause.

Test Plan:
- Reset, then q_valid=1, q_mode=3, instr_boundary=1, pc_next=0x100 -> next cycle take_int=1, q_dequeue=1, redirect_pc=0xB0, epc=0x100, cause=3, ie=0; following cycle in_handler=1, take_int=0.
- In HANDLER, pulse eret -> next cycle take_ret=1, redirect_pc=0x100, ie=1; then IDLE, in_handler=0.
- Two queued entries (modes 2, 5), boundary held high -> first entry serviced, second ignored until after eret/RETURN, then take_int with redirect_pc=0xD0. Exactly two q_dequeue pulses total.
- q_mode=0 at accept -> single q_dequeue pulse, no take_int, spurious_cnt=1, epc unchanged. 260 such entries -> spurious_cnt=255.
- ie_write=1, ie_wdata=0, then q_valid=1 with boundary -> no accept, no dequeue. ie_write in the same cycle as an accepting boundary -> ie=0 (FSM wins).
- rst asserted while in HANDLER -> next cycle IDLE, ie=1, epc=0, all pulses 0. An eret after the reset produces no take_ret.
